// File: rtl/cs_map.sv
// cs_map : bus-cycle chip-select decoder and boot-overlay controller for the
// 68HC000 side of the accelerator CPLD.
//
// Ports
//   CLK         in   CPU-domain clock
//   nRES        in   asynchronous active-low reset
//   A[15:0]     in   CPU address bits A[23:8]
//   nWE         in   CPU write strobe, low = write
//   BACT        in   bus cycle active
//   Overlay     out  1 = boot ROM mirrored at address 0
//   ROMCS, ROMCS4X, SndROMCS        out  ROM selects
//   RAMCS, RAMCS0X, SndRAMCSWR      out  RAM selects
//   IOCS, IOPWCS, IACS              out  IO-bridge, posted-write snoop, IACK
//   dbg_state   out  overlay FSM state (0 = OVL_ON, 1 = OVL_OFF)
//
// Handshake: there is no valid/ready pair here. BACT high marks a CPU bus
// cycle in progress; a cycle is complete on the first CLK edge that samples
// BACT low. The overlay state only ever changes on such an edge.
//
// Build option: define CS_LATCH_EN to hold every select stable from the
// second clock of a bus cycle until BACT falls. Without it all selects are
// purely combinational and no latch flops exist.

module cs_map #(
    parameter int          OVL_EXIT_HITS = 1,
    parameter logic [15:0] IO_MASK       = 16'hFFE0,
    parameter logic [7:0]  WIN_BASE      = 8'h3F,
    parameter logic [15:0] VID_PAGE_MASK = 16'hFCFC,
    parameter logic [15:0] SND_A_MASK    = 16'h000E,
    parameter logic [15:0] SND_F_MASK    = 16'hE000
) (
    input  logic        CLK,
    input  logic        nRES,
    input  logic [15:0] A,
    input  logic        nWE,
    input  logic        BACT,
    output logic        Overlay,
    output logic        ROMCS,
    output logic        ROMCS4X,
    output logic        SndROMCS,
    output logic        RAMCS,
    output logic        RAMCS0X,
    output logic        SndRAMCSWR,
    output logic        IOCS,
    output logic        IOPWCS,
    output logic        IACS,
    output logic        dbg_state
);

    typedef enum logic {
        OVL_ON  = 1'b0,
        OVL_OFF = 1'b1
    } ovl_state_e;

    localparam logic [3:0] EXIT_HITS = 4'(OVL_EXIT_HITS);

    ovl_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hit_q, hit_d;
    logic       run_q, run_d;     // low only on the first edge after reset release
    logic [3:0] cnt_inc;

    logic       ovl;
    logic [3:0] seg;
    logic       rom4x_c, romcs_c, sndrom_c, ram0x_c, ramcs_c;
    logic       win_c, iopw_c, sndram_c, iacs_c, iocs_c;
    logic [8:0] sel_c;
    logic [8:0] sel_out;

    assign ovl = (state_q == OVL_ON);
    assign seg = A[15:12];

    // ---------------- address decode ----------------
    always_comb begin
        rom4x_c  = (seg == 4'h4);
        romcs_c  = rom4x_c | ((seg == 4'h0) & ovl);
        sndrom_c = rom4x_c & ((A[11:0] == 12'h36C) | (A[11:0] == 12'h36D) |
                              (A[11:0] == 12'h36F));
        ram0x_c  = (A[15:14] == 2'b00);
        ramcs_c  = ram0x_c & ~ovl;
        win_c    = ram0x_c & ~nWE & (A[15:8] == WIN_BASE);
        iopw_c   = win_c & VID_PAGE_MASK[A[7:4]];
        sndram_c = win_c & (((A[7:4] == 4'hA) & SND_A_MASK[A[3:0]]) |
                            ((A[7:4] == 4'hF) & SND_F_MASK[A[3:0]]));
        iacs_c   = (A[15:8] == 8'hFF);
        // The 4X region reaches the IO bridge while the overlay is active.
        iocs_c   = IO_MASK[seg] | (rom4x_c & ovl) | iopw_c;
        sel_c    = {romcs_c, rom4x_c, sndrom_c, ramcs_c, ram0x_c,
                    sndram_c, iocs_c, iopw_c, iacs_c};
    end

    // ---------------- overlay FSM ----------------
    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        run_d   = 1'b1;
        if (run_q && state_q == OVL_ON) begin
            if (BACT) begin
                if (rom4x_c) begin
                    hit_d = 1'b1;
                end
            end else if (hit_q) begin
                // One count per completed cycle, however many clocks it took.
                hit_d = 1'b0;
                if (cnt_q < EXIT_HITS) begin
                    cnt_d = cnt_inc;
                end
                if (cnt_inc == EXIT_HITS) begin
                    state_d = OVL_OFF;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state_q <= OVL_ON;
            cnt_q   <= 4'd0;
            hit_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            run_q   <= run_d;
        end
    end

`ifdef CS_LATCH_EN
    // ---------------- per-cycle select latch ----------------
    logic       bact_q, bact_d;
    logic       lat_act_q, lat_act_d;
    logic [8:0] lat_q, lat_d;

    always_comb begin
        bact_d    = BACT;
        lat_d     = lat_q;
        lat_act_d = 1'b0;
        if (BACT) begin
            if (!bact_q) begin
                lat_d     = sel_c;
                lat_act_d = 1'b1;
            end else begin
                lat_act_d = lat_act_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            bact_q    <= 1'b0;
            lat_act_q <= 1'b0;
            lat_q     <= 9'd0;
        end else begin
            bact_q    <= bact_d;
            lat_act_q <= lat_act_d;
            lat_q     <= lat_d;
        end
    end

    // Gated with BACT so the selects return to live decode as soon as BACT drops.
    assign sel_out = (lat_act_q & BACT) ? lat_q : sel_c;
`else
    assign sel_out = sel_c;
`endif

    assign {ROMCS, ROMCS4X, SndROMCS, RAMCS, RAMCS0X,
            SndRAMCSWR, IOCS, IOPWCS, IACS} = sel_out;
    assign Overlay   = ovl;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cs_map.sv
module tb_cs_map;

    localparam logic [15:0] IO_M  = 16'hFFE0;
    localparam logic [15:0] VID_M = 16'hFCFC;
    localparam logic [15:0] SA_M  = 16'h000E;
    localparam logic [15:0] SF_M  = 16'hE000;
    localparam int          WIN   = 8'h3F;

    logic        CLK = 1'b0;
    logic        nRES, nWE, BACT;
    logic [15:0] A;

    logic [8:0] sel1, sel3;
    logic       ovl1, ovl3, dbg1, dbg3;
    logic [19:0] obs, exp_v;
    assign obs = {sel1, ovl1, sel3, ovl3};

    int errors = 0;
    int checks = 0;
    int hits   = 0;   // completed bus cycles that touched the 4X region since reset
    bit cyc_4x;

    always #5 CLK = ~CLK;

    cs_map #(.OVL_EXIT_HITS(1)) dut1 (
        .CLK(CLK), .nRES(nRES), .A(A), .nWE(nWE), .BACT(BACT), .Overlay(ovl1),
        .ROMCS(sel1[8]), .ROMCS4X(sel1[7]), .SndROMCS(sel1[6]), .RAMCS(sel1[5]),
        .RAMCS0X(sel1[4]), .SndRAMCSWR(sel1[3]), .IOCS(sel1[2]), .IOPWCS(sel1[1]),
        .IACS(sel1[0]), .dbg_state(dbg1));

    cs_map #(.OVL_EXIT_HITS(3)) dut3 (
        .CLK(CLK), .nRES(nRES), .A(A), .nWE(nWE), .BACT(BACT), .Overlay(ovl3),
        .ROMCS(sel3[8]), .ROMCS4X(sel3[7]), .SndROMCS(sel3[6]), .RAMCS(sel3[5]),
        .RAMCS0X(sel3[4]), .SndRAMCSWR(sel3[3]), .IOCS(sel3[2]), .IOPWCS(sel3[1]),
        .IACS(sel3[0]), .dbg_state(dbg3));

    // Reference decode from the address map, using plain integer arithmetic.
    function automatic logic [8:0] exp_sel(input int a, input bit nwe, input bit ov);
        int seg, low12, bank, page, sub;
        bit rom4x, romcs, sndrom, ram0x, ramcs, win, iopw, sndram, iacs, iocs;
        seg    = a / 4096;
        low12  = a % 4096;
        bank   = a / 256;
        page   = (a / 16) % 16;
        sub    = a % 16;
        rom4x  = (seg == 4);
        romcs  = rom4x || (seg == 0 && ov);
        sndrom = rom4x && (low12 == 'h36C || low12 == 'h36D || low12 == 'h36F);
        ram0x  = (a < 16384);
        ramcs  = ram0x && !ov;
        win    = ram0x && !nwe && (bank == WIN);
        iopw   = win && VID_M[page];
        sndram = win && ((page == 10 && SA_M[sub]) || (page == 15 && SF_M[sub]));
        iacs   = (bank == 255);
        iocs   = IO_M[seg] || (rom4x && ov) || iopw;
        return {romcs, rom4x, sndrom, ramcs, ram0x, sndram, iocs, iopw, iacs};
    endfunction

    function automatic logic [19:0] exp_all(input int a, input bit nwe);
        bit e1, e3;
        e1 = (hits < 1);
        e3 = (hits < 3);
        return {exp_sel(a, nwe, e1), e1, exp_sel(a, nwe, e3), e3};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_assert();
        nRES = 1'b0;
        hits = 0;
        #1;
    endtask

    task automatic reset_release();
        BACT = 1'b0;
        @(posedge CLK);
        #1;
        nRES = 1'b1;
        tick();   // first edge after release: FSM idle
        tick();
    endtask

    task automatic start_cycle(input int a, input bit nwe);
        A      = a[15:0];
        nWE    = nwe;
        BACT   = 1'b1;
        cyc_4x = (a / 4096 == 4);
        #1;
    endtask

    task automatic finish_cycle(input int len);
        repeat (len) tick();
        BACT = 1'b0;
        tick();
        if (cyc_4x) hits++;
        cyc_4x = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        A = 16'h0000; nWE = 1'b1; BACT = 1'b1;
        reset_assert();
        #1;
        exp_v = exp_all(0, 1);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL reset_state: got %h want %h", obs, exp_v);
        end
        reset_release();
    endtask

    task automatic test_overlay_exit();
        start_cycle('h0000, 1);
        exp_v = exp_all('h0000, 1);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL boot_rom_at_0: got %h want %h", obs, exp_v);
        end
        finish_cycle(1);
        start_cycle('h4000, 1);
        finish_cycle(2);
        exp_v = exp_all('h4000, 1);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL overlay_exit_1: got %h want %h", obs, exp_v);
        end
        A = 16'h0000; #1;
        exp_v = exp_all('h0000, 1);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL ram_at_0: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_hits();
        reset_assert();
        reset_release();
        for (int k = 1; k <= 3; k++) begin
            start_cycle('h4000 + k * 16, 1);
            finish_cycle(k == 2 ? 5 : 1);
            exp_v = exp_all('h4000 + k * 16, 1);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL hit_%0d: got %h want %h", k, obs, exp_v);
            end
            if (k == 1) begin
                start_cycle('h5000, 1);   // non-4X pulse must not count
                finish_cycle(3);
                exp_v = exp_all('h5000, 1);
                checks++;
                if (obs !== exp_v) begin
                    errors++; $display("FAIL non4x_pulse: got %h want %h", obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        reset_assert();
        reset_release();
        start_cycle('h4000, 1);
        tick(); tick();
        A = 16'h4100; tick();
        A = 16'h4200; tick();
        BACT = 1'b0; tick();
        hits++;
        exp_v = exp_all('h4200, 1);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL merged_hits: got %h want %h", obs, exp_v);
        end
        start_cycle('h4000, 1);
        tick();
        A = 16'h0000; tick();
        BACT = 1'b0; tick();
        hits++;
        exp_v = exp_all('h0000, 1);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL hit_then_leave: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_snoop();
        int addrs[3] = '{'h3FF0, 'h3FFD, 'h3FFD};
        bit nwes[3]  = '{1'b0, 1'b0, 1'b1};
        start_cycle('h3FF0, 0);
        for (int i = 0; i < 3; i++) begin
            A = addrs[i][15:0]; nWE = nwes[i]; #1;
            exp_v = exp_all(addrs[i], nwes[i]);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL snoop_%0d: got %h want %h", i, obs, exp_v);
            end
        end
        finish_cycle(1);
    endtask

    task automatic test_io_sweep();
        int addrs[4] = '{'h5000, 'h9000, 'hFF00, 'h4000};
        BACT = 1'b0; nWE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            A = addrs[i][15:0]; #1;
            exp_v = exp_all(addrs[i], 1);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL io_sweep_%h: got %h want %h", addrs[i], obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        start_cycle('h0000, 1);
        tick();
        #2;
        reset_assert();
        exp_v = exp_all('h0000, 1);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL async_reset: got %h want %h", obs, exp_v);
        end
        reset_release();
        for (int k = 1; k <= 3; k++) begin
            start_cycle('h4000, 1);
            finish_cycle(1);
            exp_v = exp_all('h4000, 1);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL restart_hit_%0d: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_latch();
        start_cycle('h3FF0, 0);
        tick();
        A = 16'h1000; #1;
`ifdef CS_LATCH_EN
        exp_v = exp_all('h3FF0, 0);
`else
        exp_v = exp_all('h1000, 0);
`endif
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL midcycle_hold: got %h want %h", obs, exp_v);
        end
        BACT = 1'b0; #1;
        exp_v = exp_all('h1000, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL after_bact_fall: got %h want %h", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_random();
        int a, len;
        bit nwe;
        reset_assert();
        reset_release();
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 65535);
                1: a = 'h3F00 + $urandom_range(0, 255);
                2: a = 'h4360 + $urandom_range(0, 15);
                default: a = $urandom_range(0, 15) * 4096;
            endcase
            nwe = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 4);
            start_cycle(a, nwe);
            exp_v = exp_all(a, nwe);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL rand_in_%0d a=%h: got %h want %h", i, a, obs, exp_v);
            end
            finish_cycle(len);
            exp_v = exp_all(a, nwe);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL rand_end_%0d a=%h: got %h want %h", i, a, obs, exp_v);
            end
            repeat ($urandom_range(0, 1)) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        nRES = 1'b0; A = '0; nWE = 1'b1; BACT = 1'b0; cyc_4x = 1'b0;
        test_reset();
        test_overlay_exit();
        test_hits();
        test_back_to_back();
        test_snoop();
        test_io_sweep();
        test_async_reset();
        test_latch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
